// File: rtl/unsigned_mul_8x8_pkg.sv
// Shared constants, row type and row weighting for the 8x8 approximate multiplier.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package unsigned_mul_8x8_pkg;

  localparam int ROWS      = 4;
  localparam int T_W       = 9;
  localparam int B_W       = 7;
  localparam int ROW_SHIFT = 2;
  // t + (b << 2) peaks at 511 + 508 = 1019, so one extra bit over t suffices
  localparam int ROW_W     = T_W + 1;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [B_W-1:0] b;
  } row_t;

  // Unshifted row value: b bits sit ROW_SHIFT places above the matching t bits
  function automatic logic [ROW_W-1:0] row_value(input row_t r);
    return ROW_W'(r.t) + (ROW_W'(r.b) << ROW_SHIFT);
  endfunction

endpackage

// File: rtl/unsigned_mul_8x8_ha_reduce_if.sv
// Row-set input handshake and product output handshake of the reduction stage.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready carry valid/ready flow control in each direction.
interface unsigned_mul_8x8_ha_reduce_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       ha_array_0_t;
  logic [8:0]       ha_array_1_t;
  logic [8:0]       ha_array_2_t;
  logic [8:0]       ha_array_3_t;
  logic [6:0]       ha_array_0_b;
  logic [6:0]       ha_array_1_b;
  logic [6:0]       ha_array_2_b;
  logic [6:0]       ha_array_3_b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] product;

  // Upstream/downstream environment side
  modport master (
    output in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    input  in_ready, out_valid, product
  );

  // Reduction stage side
  modport slave (
    input  in_valid, ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
           ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/unsigned_mul_8x8_pipe_stage.sv
// Generic valid/ready register slice carrying DAT_W bits of payload.
// Latency: 1 cycle.
// Backpressure: in_rdy = !out_vld | out_rdy; a held slice keeps its payload unchanged.
module unsigned_mul_8x8_pipe_stage #(
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DAT_W-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DAT_W-1:0] out_dat
);

  // Slice may load whenever it is empty or its content leaves this cycle
  assign in_rdy = !out_vld || out_rdy;

  // Valid follows the input on every advance; an advance with no input empties the slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= in_vld;
    end
  end

  // Payload only loads on an actual transfer, so bubbles leave the last data in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat <= '0;
    end else if (in_rdy && in_vld) begin
      out_dat <= in_dat;
    end
  end

endmodule

// File: rtl/unsigned_mul_8x8_ha_reduce.sv
// Weights and sums the four half-adder rows into the 16-bit approximate product.
// Latency: 2 cycles (pair sums, then final sum); throughput 1 per cycle.
// Backpressure: out_ready stalls stage 2, then stage 1, then in_ready; at most 2 in flight.
module unsigned_mul_8x8_ha_reduce
  import unsigned_mul_8x8_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int PAIR_W = 13   // must hold 1019 * 5 = 5095
) (
  input  logic                         clk,
  input  logic                         rst_n,
  unsigned_mul_8x8_ha_reduce_if.slave  bus
);

  row_t               rows [ROWS];
  logic [ROW_W-1:0]   rv   [ROWS];
  logic [PAIR_W-1:0]  pa_nxt;
  logic [PAIR_W-1:0]  pb_nxt;
  logic [2*PAIR_W-1:0] s1_dat;
  logic [PAIR_W-1:0]  s1_pa;
  logic [PAIR_W-1:0]  s1_pb;
  logic               s1_vld;
  logic               s2_rdy;
  logic [OUT_W-1:0]   sum_nxt;

  assign rows[0] = {bus.ha_array_0_t, bus.ha_array_0_b};
  assign rows[1] = {bus.ha_array_1_t, bus.ha_array_1_b};
  assign rows[2] = {bus.ha_array_2_t, bus.ha_array_2_b};
  assign rows[3] = {bus.ha_array_3_t, bus.ha_array_3_b};

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign rv[i] = row_value(rows[i]);
  end

  // Adjacent rows differ by ROW_SHIFT in weight; pair B is rows 2/3 relative to row 2
  assign pa_nxt = PAIR_W'(rv[0]) + (PAIR_W'(rv[1]) << ROW_SHIFT);
  assign pb_nxt = PAIR_W'(rv[2]) + (PAIR_W'(rv[3]) << ROW_SHIFT);

  unsigned_mul_8x8_pipe_stage #(
    .DAT_W (2*PAIR_W)
  ) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (bus.in_valid),
    .in_rdy  (bus.in_ready),
    .in_dat  ({pa_nxt, pb_nxt}),
    .out_vld (s1_vld),
    .out_rdy (s2_rdy),
    .out_dat (s1_dat)
  );

  assign s1_pa = s1_dat[2*PAIR_W-1:PAIR_W];
  assign s1_pb = s1_dat[PAIR_W-1:0];

  // Pair B sits two rows (2*ROW_SHIFT bits) above pair A; computing in OUT_W wraps modulo 2^OUT_W
  assign sum_nxt = OUT_W'(s1_pa) + (OUT_W'(s1_pb) << (2*ROW_SHIFT));

  unsigned_mul_8x8_pipe_stage #(
    .DAT_W (OUT_W)
  ) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (s1_vld),
    .in_rdy  (s2_rdy),
    .in_dat  (sum_nxt),
    .out_vld (bus.out_valid),
    .out_rdy (bus.out_ready),
    .out_dat (bus.product)
  );

endmodule

// File: doc/unsigned_mul_8x8_ha_reduce.md
Name: unsigned_mul_8x8_ha_reduce

Overview:
- Final reduction stage for the 8x8 unsigned approximate multiplier. It sits directly downstream of the half-adder array stage.
- Consumes the four ha_array rows (each a 9-bit t vector and a 7-bit b vector), weights and sums them, and delivers the 16-bit product.
- Two-stage elastic pipeline with valid/ready handshakes on both sides, so it can sit in a streaming datapath with backpressure.

Parameters:
- OUT_W, 16, product width; results are truncated modulo 2^OUT_W.
- PAIR_W, 13, width of the stage-1 pair-sum registers. Must be at least 13.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input row set is valid.
- in_ready  out  1  block can accept the input row set this cycle.
- ha_array_0_t .. ha_array_3_t  in  9 each  t vectors of rows 0-3.
- ha_array_0_b .. ha_array_3_b  in  7 each  b vectors of rows 0-3.
- out_valid  out  1  product is valid.
- out_ready  in  1  downstream accepts the product.
- product  out  OUT_W  reduced product.

Behaviour:
- Bit weights for row i (i = 0..3):
  - t[k] has weight 2^(2i+k).
  - b[k] has weight 2^(2i+k+2).
  - Row value R_i = (t + (b << 2)) << 2i. The unshifted term t + (b << 2) is 10 bits, max 1019.
- Stage 1, on handshake acceptance (in_valid & in_ready):
  - pA <= (t0 + (b0 << 2)) + ((t1 + (b1 << 2)) << 2)
  - pB <= (t2 + (b2 << 2)) + ((t3 + (b3 << 2)) << 2)
  - s1_valid <= 1.
  - Max pair value is 5095, which fits 13 bits.
- Stage 2, when stage 1 advances:
  - product <= (pA + (pB << 4)) mod 2^OUT_W
  - out_valid <= s1_valid.
- Advance rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational and contains no combinational path from in_valid.
- If stage 1 advances without a new input, s1_valid <= 0.
- A held stage keeps its data registers unchanged.
- Latency: an input accepted at edge N appears as out_valid=1 after edge N+1, i.e. two register stages. Throughput is 1 per cycle when out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, product and out_valid are held stable.
  - Stage 1 fills, then in_ready=0.
  - At most 2 transactions are in flight.
- Simultaneous events: with out_ready=1 and the pipeline full, a new input is accepted in the same cycle one result leaves. No bubble, no loss.
- Ordering: results leave in strict acceptance order, with no duplication or drop.
- Reset, asserted at any time including mid-stream:
  - s1_valid=0, out_valid=0, product=0, pA=pB=0 immediately.
  - In-flight data is discarded.
  - in_ready=1 during and after reset.
- Arithmetic: unsigned throughout. The final sum can exceed 2^16 only for non-physical all-ones inputs; it wraps modulo 2^OUT_W with no saturation.
- No X propagation: data registers are reset, and the output is defined whenever out_valid=1.

Decomposition:
- Shared package unsigned_mul_8x8_pkg holds:
  - ROWS=4, T_W=9, B_W=7, ROW_SHIFT=2.
  - Typedef row_t {t[8:0], b[6:0]}.
  - The weighting function row_value(row_t) returning 10 bits.
- One sub-module, unsigned_mul_8x8_pipe_stage: a generic valid/ready register slice with a data-width parameter, instantiated twice.
- The adders stay in the top module.

Test Plan:
- All rows zero, single transfer, out_ready=1 -> after 2 cycles product=0, out_valid pulses for 1 cycle.
- Row0 t=9'h001, all else zero -> product=1. Row3 b=7'h40 only -> product=16384. Row1 t=9'h100 only -> product=1024.
- All t=9'h1FF, all b=7'h7F -> 1019*85 = 86615 wraps to product=21079.
- Stream 3 distinct transfers with out_ready=0 for 5 cycles:
  - in_ready falls after 2 accepted and the third is held.
  - product stays stable while stalled.
  - After out_ready=1, results emerge in order, one per cycle.
- Continuous back-to-back input with out_ready=1 -> in_ready stays 1 and every cycle yields the matching product at 2-cycle latency.
- Assert rst_n=0 asynchronously with 2 transfers in flight -> out_valid=0 and product=0 immediately without a clock edge, in_ready=1. After release, the first new transfer is produced correctly.
